mem_stage_lsu: RTL

The MEM-stage load/store unit sits directly downstream of the EX datapath. It holds the EX/MEM pipeline register. It drives a request/grant/response data-memory port, aligning store data and byte enables and sign- or zero-extending load data. It asserts a stall to the hazard unit until the in-flight memory access completes.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/mem_stage_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Access encodings, FSM states and the access legality rule.
package cpu_pkg;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Unsigned variants exist only for loads; halfwords need addr[0]=0.
    function automatic logic access_legal(
        input logic [2:0] f3,
        input logic [1:0] a,
        input logic       ld
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !a[0];
            F3_W:    ok = (a == 2'b00);
            F3_BU:   ok = ld;
            F3_HU:   ok = ld && !a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane/byte-enable generation, load extraction/extension
// and access legality for a 32-bit data port.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_load_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        legal_o
);

    logic [31:0] shifted;

    always_comb begin
        wdata_o = wdata_i;
        be_o    = 4'b0000;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'b10:   be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_o = shifted;
            F3_BU:   rdata_o = {24'b0, shifted[7:0]};
            F3_HU:   rdata_o = {16'b0, shifted[15:0]};
            default: rdata_o = '0;
        endcase
    end

    assign legal_o = access_legal(funct3_i, addr_lo_i, is_load_i);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX/MEM register, data-memory
// request/grant/response FSM and hazard stall generation.
module mem_stage_lsu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_ADDR_WIDTH     = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          alu_res_EX,
    input  logic [DATA_WIDTH-1:0]          write_data_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           reg_write_EX,
    input  logic                           mem_write_EX,
    input  logic [1:0]                     result_sel_EX,
    input  logic [2:0]                     funct3_EX,
    input  logic [6:0]                     opcode_EX,
    input  logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_EX,
    input  logic                           flush_EX_MEM,
    output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
    output logic                           reg_write_EX_MEM_o,
    output logic [1:0]                     result_sel_EX_MEM_o,
    output logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o,
    output logic [DATA_WIDTH-1:0]          load_data_MEM,
    output logic                           mem_stall,
    output logic                           mem_fault_MEM,
    output logic                           dmem_req,
    output logic                           dmem_we,
    output logic [DATA_ADDR_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]          dmem_wdata,
    output logic [3:0]                     dmem_be,
    input  logic                           dmem_gnt,
    input  logic                           dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]          dmem_rdata
);

    logic [DATA_WIDTH-1:0]          alu_res_q;
    logic [DATA_WIDTH-1:0]          wdata_q;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
    logic                           reg_write_q;
    logic                           mem_write_q;
    logic                           is_load_q;
    logic [1:0]                     result_sel_q;
    logic [2:0]                     funct3_q;
    logic [DATA_ADDR_WIDTH-1:0]     pc4_q;

    lsu_state_e state_q, state_d;

    logic        is_load_ex;
    logic        new_acc;
    logic        legal_q;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] rdata_ext;

    assign is_load_ex = (opcode_EX == OPCODE_LOAD);
    // A legal access loaded on this edge enters REQ directly.
    assign new_acc = !flush_EX_MEM
                   && (is_load_ex || mem_write_EX)
                   && access_legal(funct3_EX, alu_res_EX[1:0], is_load_ex);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q    <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            is_load_q    <= 1'b0;
            result_sel_q <= '0;
            funct3_q     <= '0;
            pc4_q        <= '0;
        end else if (!mem_stall) begin
            alu_res_q    <= alu_res_EX;
            wdata_q      <= write_data_EX;
            rd_q         <= rd_EX;
            result_sel_q <= result_sel_EX;
            funct3_q     <= funct3_EX;
            pc4_q        <= PC_plus_4_EX;
            reg_write_q  <= reg_write_EX && !flush_EX_MEM;
            mem_write_q  <= mem_write_EX && !flush_EX_MEM;
            is_load_q    <= is_load_ex && !flush_EX_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (alu_res_q[1:0]),
        .is_load_i (is_load_q),
        .wdata_i   (wdata_q),
        .rdata_i   (dmem_rdata),
        .wdata_o   (wdata_al),
        .be_o      (be),
        .rdata_o   (rdata_ext),
        .legal_o   (legal_q)
    );

    always_comb begin
        state_d       = state_q;
        dmem_req      = 1'b0;
        mem_stall     = 1'b0;
        load_data_MEM = '0;
        unique case (state_q)
            IDLE: state_d = new_acc ? REQ : IDLE;
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = !dmem_gnt || is_load_q;
                if (dmem_gnt)
                    state_d = is_load_q ? RESP : (new_acc ? REQ : IDLE);
            end
            RESP: begin
                mem_stall = !dmem_rvalid;
                if (dmem_rvalid) begin
                    load_data_MEM = rdata_ext;
                    state_d       = new_acc ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_fault_MEM       = (is_load_q || mem_write_q) && !legal_q;
    assign dmem_we             = mem_write_q && !is_load_q;
    assign dmem_addr           = {alu_res_q[DATA_ADDR_WIDTH-1:2], 2'b00};
    assign dmem_wdata          = wdata_al;
    assign dmem_be             = dmem_we ? be : 4'b0000;
    assign alu_res_EX_MEM_o    = alu_res_q;
    assign rd_EX_MEM_o         = rd_q;
    assign reg_write_EX_MEM_o  = reg_write_q && !mem_fault_MEM;
    assign result_sel_EX_MEM_o = result_sel_q;
    assign PC_plus_4_EX_MEM_o  = pc4_q;

endmodule
